// File: rtl/srl_fifo_buffer_pkg.sv
// Shared helpers for the SRL-based FIFO buffer.
package srl_fifo_buffer_pkg;

    // Bits needed to address 'value' distinct locations (minimum 0).
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/srl_fifo_buffer_pipeline.sv
// Variable-tap shift-register pipeline: words shift in at position 0 and the
// word at the registered tap position is presented on data_out. Storage has no
// reset, so it maps onto SRL16E/SRLC32E primitives; only the tap register
// clears.
module srl_fifo_buffer_pipeline
    import srl_fifo_buffer_pkg::*;
#(
    parameter int WORD_WIDTH = 8,
    parameter int PIPE_DEPTH = 16,
    parameter int ADDR_WIDTH = clog2(PIPE_DEPTH)
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  shift_data,
    input  logic                  tap_number_load,
    input  logic [ADDR_WIDTH-1:0] tap_number,
    input  logic [WORD_WIDTH-1:0] data_in,
    output logic [WORD_WIDTH-1:0] data_out
);

    logic [WORD_WIDTH-1:0] pipe [PIPE_DEPTH];
    logic [ADDR_WIDTH-1:0] tap;

    // Shift chain: new word enters at position 0, every stored word moves up one.
    always_ff @(posedge clock) begin
        if (shift_data) begin
            pipe[0] <= data_in;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    // Tap address register; cleared so the read mux points at position 0.
    always_ff @(posedge clock) begin
        if (clear) begin
            tap <= '0;
        end else if (tap_number_load) begin
            tap <= tap_number;
        end
    end

    // Read mux driven by the registered tap.
    always_comb begin
        data_out = pipe[tap];
    end

endmodule

// File: rtl/srl_fifo_buffer.sv
// Ready/valid FIFO over the variable-tap SRL pipeline. The tap tracks
// occupancy so the oldest stored word always sits at the output.
//
// Handshake: a word moves on a port only in a cycle where both valid and
// ready are high at the rising clock edge. input_ready and output_valid are
// decoded from registered state only, so neither depends on the handshake
// inputs of the same cycle; valid must not wait on ready.
module srl_fifo_buffer
    import srl_fifo_buffer_pkg::*;
#(
    parameter int WORD_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = clog2(DEPTH)
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  input_valid,
    output logic                  input_ready,
    input  logic [WORD_WIDTH-1:0] input_data,
    output logic                  output_valid,
    input  logic                  output_ready,
    output logic [WORD_WIDTH-1:0] output_data
);

    localparam logic [ADDR_WIDTH:0]   COUNT_ZERO = '0;
    localparam logic [ADDR_WIDTH:0]   COUNT_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0]   COUNT_FULL = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH:0]   count;
    logic [ADDR_WIDTH:0]   count_next;
    logic [ADDR_WIDTH-1:0] tap_next;
    logic                  push;
    logic                  pop;
    logic [WORD_WIDTH-1:0] pipeline_data;

    // Flags come from the registered count only; full blocks a push even when
    // a pop happens in the same cycle.
    always_comb begin
        input_ready  = (count != COUNT_FULL);
        output_valid = (count != COUNT_ZERO);
        push         = input_valid & input_ready;
        pop          = output_valid & output_ready;
    end

    // Next occupancy and the tap that will point at the oldest word after it.
    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + COUNT_ONE;
        end else if (pop && !push) begin
            count_next = count - COUNT_ONE;
        end
        // Truncated (count_next - 1); wraps harmlessly when empty since output is masked.
        tap_next = count_next[ADDR_WIDTH-1:0] - ADDR_ONE;
    end

    // Occupancy register; only updates when exactly one of push/pop happens.
    always_ff @(posedge clock) begin
        if (clear) begin
            count <= COUNT_ZERO;
        end else if (push ^ pop) begin
            count <= count_next;
        end
    end

    srl_fifo_buffer_pipeline #(
        .WORD_WIDTH (WORD_WIDTH),
        .PIPE_DEPTH (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_pipeline (
        .clock           (clock),
        .clear           (clear),
        .shift_data      (push),
        .tap_number_load (1'b1),
        .tap_number      (tap_next),
        .data_in         (input_data),
        .data_out        (pipeline_data)
    );

    // Stale SRL contents stay hidden whenever the FIFO is empty.
    always_comb begin
        output_data = output_valid ? pipeline_data : '0;
    end

endmodule

// File: tb/tb_srl_fifo_buffer.sv
// Directed bench for srl_fifo_buffer: a DEPTH=16 and a DEPTH=32 instance.
module tb_srl_fifo_buffer;

    logic clock;

    // DEPTH=16 instance
    logic       a_clear, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [7:0] a_in_data, a_out_data;
    // DEPTH=32 instance
    logic       b_clear, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [7:0] b_in_data, b_out_data;

    int total;
    int bad;
    logic [7:0] exp_q[$];
    logic [7:0] exp_word;

    srl_fifo_buffer #(.WORD_WIDTH(8), .DEPTH(16)) dut16 (
        .clock        (clock),
        .clear        (a_clear),
        .input_valid  (a_in_valid),
        .input_ready  (a_in_ready),
        .input_data   (a_in_data),
        .output_valid (a_out_valid),
        .output_ready (a_out_ready),
        .output_data  (a_out_data)
    );

    srl_fifo_buffer #(.WORD_WIDTH(8), .DEPTH(32)) dut32 (
        .clock        (clock),
        .clear        (b_clear),
        .input_valid  (b_in_valid),
        .input_ready  (b_in_ready),
        .input_data   (b_in_data),
        .output_valid (b_out_valid),
        .output_ready (b_out_ready),
        .output_data  (b_out_data)
    );

    // Clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Single comparison point
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total = total + 1;
        if (got !== want) begin
            bad = bad + 1;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Advance one clock and settle 1ns past the rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        a_clear = 1'b1; a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
        b_clear = 1'b1; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;

        // Reset / empty
        step();
        step();
        check("clr_in_ready", 32'(a_in_ready), 32'd1);
        check("clr_out_valid", 32'(a_out_valid), 32'd0);
        check("clr_out_data", 32'(a_out_data), 32'd0);
        a_clear = 1'b0;
        b_clear = 1'b0;
        step();
        check("rel_in_ready", 32'(a_in_ready), 32'd1);
        check("rel_out_valid", 32'(a_out_valid), 32'd0);
        check("rel_out_data", 32'(a_out_data), 32'd0);
        check("rel_b_in_ready", 32'(b_in_ready), 32'd1);
        a_out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("empty_pop_count", 32'(dut16.count), 32'd0);
            check("empty_pop_valid", 32'(a_out_valid), 32'd0);
        end
        a_out_ready = 1'b0;

        // Fill 0x01..0x10 with the consumer stalled
        for (int i = 1; i <= 16; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = 8'(i);
            step();
        end
        check("full_in_ready", 32'(a_in_ready), 32'd0);
        check("full_count", 32'(dut16.count), 32'd16);
        a_in_data = 8'hFF;
        step();
        a_in_valid = 1'b0;
        check("overflow_count", 32'(dut16.count), 32'd16);
        check("overflow_in_ready", 32'(a_in_ready), 32'd0);
        a_out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            check("drain_valid", 32'(a_out_valid), 32'd1);
            check("drain_data", 32'(a_out_data), 32'(i));
            step();
        end
        a_out_ready = 1'b0;
        check("drained_valid", 32'(a_out_valid), 32'd0);
        check("drained_data", 32'(a_out_data), 32'd0);

        // Preload three words, then push and pop every cycle
        for (int i = 0; i < 3; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = 8'hA0 + 8'(i);
            exp_q.push_back(a_in_data);
            step();
        end
        for (int k = 0; k < 10; k++) begin
            a_in_valid  = 1'b1;
            a_in_data   = 8'hB0 + 8'(k);
            a_out_ready = 1'b1;
            exp_word = exp_q.pop_front();
            exp_q.push_back(a_in_data);
            check("pp_count", 32'(dut16.count), 32'd3);
            check("pp_valid", 32'(a_out_valid), 32'd1);
            check("pp_data", 32'(a_out_data), 32'(exp_word));
            step();
        end
        a_in_valid = 1'b0;
        check("pp_count_end", 32'(dut16.count), 32'd3);
        while (exp_q.size() > 0) begin
            exp_word = exp_q.pop_front();
            check("pp_tail_data", 32'(a_out_data), 32'(exp_word));
            step();
        end
        a_out_ready = 1'b0;
        check("pp_empty", 32'(a_out_valid), 32'd0);

        // Push into empty: one-cycle latency
        a_in_valid = 1'b1;
        a_in_data  = 8'h5A;
        check("single_pre_valid", 32'(a_out_valid), 32'd0);
        step();
        a_in_valid = 1'b0;
        check("single_valid", 32'(a_out_valid), 32'd1);
        check("single_data", 32'(a_out_data), 32'h5A);
        a_out_ready = 1'b1;
        step();
        a_out_ready = 1'b0;
        check("single_popped", 32'(a_out_valid), 32'd0);

        // DEPTH=32: full with simultaneous push attempt and pop
        for (int i = 1; i <= 32; i++) begin
            b_in_valid = 1'b1;
            b_in_data  = 8'(i);
            step();
        end
        check("b_full_count", 32'(dut32.count), 32'd32);
        check("b_full_ready", 32'(b_in_ready), 32'd0);
        b_in_valid  = 1'b1;
        b_in_data   = 8'hEE;
        b_out_ready = 1'b1;
        check("b_full_head", 32'(b_out_data), 32'd1);
        step();
        b_in_valid  = 1'b0;
        b_out_ready = 1'b0;
        check("b_pop_count", 32'(dut32.count), 32'd31);
        check("b_pop_ready", 32'(b_in_ready), 32'd1);
        b_out_ready = 1'b1;
        for (int i = 2; i <= 32; i++) begin
            check("b_drain_data", 32'(b_out_data), 32'(i));
            step();
        end
        b_out_ready = 1'b0;
        check("b_drained_valid", 32'(b_out_valid), 32'd0);

        // Mid-operation clear with push and pop
        for (int i = 0; i < 7; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = 8'h70 + 8'(i);
            step();
        end
        check("mid_count", 32'(dut16.count), 32'd7);
        a_clear     = 1'b1;
        a_in_valid  = 1'b1;
        a_in_data   = 8'h77;
        a_out_ready = 1'b1;
        step();
        a_clear     = 1'b0;
        a_in_valid  = 1'b0;
        a_out_ready = 1'b0;
        check("mid_clr_count", 32'(dut16.count), 32'd0);
        check("mid_clr_valid", 32'(a_out_valid), 32'd0);
        check("mid_clr_data", 32'(a_out_data), 32'd0);
        check("mid_clr_ready", 32'(a_in_ready), 32'd1);
        a_in_valid = 1'b1;
        a_in_data  = 8'h33;
        step();
        a_in_valid = 1'b0;
        check("post_clr_valid", 32'(a_out_valid), 32'd1);
        check("post_clr_data", 32'(a_out_data), 32'h33);
        check("post_clr_count", 32'(dut16.count), 32'd1);
        a_out_ready = 1'b1;
        step();
        a_out_ready = 1'b0;
        check("post_clr_empty", 32'(a_out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/srl_fifo_buffer.md
# srl_fifo_buffer

Ready/valid FIFO built on the variable-tap SRL shift-register pipeline. It adds the read side that the bare pipeline lacks: the tap address tracks FIFO occupancy, so the oldest stored word is always presented at the output. It sits between any producer and consumer using the codebase's valid/ready handshake, where a deep LUT-based buffer is cheaper than a block RAM or register FIFO.

## Interface
Parameters:
- `WORD_WIDTH`, 0: data word width in bits; must be set at instantiation.
- `DEPTH`, 0: capacity in words; only 16 or 32 are legal, matching the SRL16E/SRLC32E primitives.
- `ADDR_WIDTH`, clog2(DEPTH): tap address width; derived, do not set except in Vivado IPI.

Ports (one clock; reset is synchronous and active-high):
- `clock`  input  1  sole clock; all state updates on its rising edge.
- `clear`  input  1  synchronous, active-high reset.
- `input_valid`  input  1  producer offers `input_data`.
- `input_ready`  output  1  FIFO can accept a word this cycle.
- `input_data`  input  WORD_WIDTH  word to enqueue.
- `output_valid`  output  1  `output_data` holds the oldest stored word.
- `output_ready`  input  1  consumer takes `output_data` this cycle.
- `output_data`  output  WORD_WIDTH  oldest stored word; forced to zero while `output_valid` is 0.

## Operation
- Occupancy counter `count` is ADDR_WIDTH+1 bits wide, range 0..DEPTH. Reset value is 0.
- Flags:
  - `push` = input_valid & input_ready
  - `pop` = output_valid & output_ready
  - `input_ready` = (count != DEPTH)
  - `output_valid` = (count != 0)
- Storage behaviour:
  - `push` shifts `input_data` into SRL position 0 and moves every stored word up one position.
  - The oldest word is always at position count-1, and that position is the tap address.
- Count update:
  - push only: count+1
  - pop only: count-1
  - push and pop together: count unchanged; the shift moves the second-oldest word into tap count-1
  - neither: hold
- The next tap address is computed as (count_next - 1) truncated to ADDR_WIDTH and loaded every cycle, so the registered tap always equals count-1.
  - When count is 0 the tap value is irrelevant, because output data is masked.
- Empty: `output_valid`=0 and no pop occurs. A push while empty is never paired with a pop in the same cycle.
- Full: `input_ready`=0 even if a pop happens in the same cycle. There is no combinational ready-to-ready path, so a push can never overflow.
- Illegal handshakes are absorbed:
  - `input_valid` while full is ignored.
  - `output_ready` while empty is ignored.
  - Count never wraps.
- Clear:
  - `count` and the tap register go to 0. On the following cycle `input_ready`=1 and `output_valid`=0.
  - SRL contents are not reset, but they are unobservable because output is masked until new pushes arrive.
  - Clear overrides a push or pop in the same cycle; that word is dropped.

## Timing
- Values while `clear` is asserted and on the first cycle after it is released: `input_ready`=1, `output_valid`=0, `output_data`=0.
- Latency from push to output: 1 cycle. A word pushed into an empty FIFO appears with `output_valid`=1 on the next cycle.
- Throughput is one push and one pop per cycle sustained, for any count between 1 and DEPTH-1.
- `input_ready` and `output_valid` are decoded from registered `count` only; neither depends combinationally on handshake inputs.
- `output_data` is combinational from the registered tap through the SRL read mux and the valid mask.

## Structure
- No shared package types are needed. Use `clog2_function.vh` for ADDR_WIDTH. Local constants are COUNT_ZERO, COUNT_ONE and COUNT_FULL (= DEPTH), all ADDR_WIDTH+1 wide.
- Count register: a `Register` instance with clock_enable = push ^ pop and clear = `clear`.
- Storage sub-module: `Register_Pipeline_Variable`, instantiated with:
  - PIPE_DEPTH=DEPTH
  - shift_data=push
  - tap_number_load=1
  - tap_number=count_next-1
  - clear=`clear`
- Output mask: `output_data` = output_valid ? pipeline output : 0.

## Test plan
- Reset/empty: assert `clear` for 2 cycles, then check `input_ready`=1, `output_valid`=0, `output_data`=0. Hold `output_ready`=1 for 5 cycles and confirm count stays 0 and nothing is popped.
- Fill/drain (DEPTH=16, WORD_WIDTH=8): push 0x01..0x10 with `output_ready`=0.
  - After the 16th push, `input_ready`=0.
  - A 17th word 0xFF is offered and must be ignored.
  - Drain and check the order 0x01..0x10, then `output_valid`=0.
- Simultaneous push/pop: preload 0xA0, 0xA1, 0xA2, then push 0xB0..0xB9 while popping every cycle.
  - Output sequence must be 0xA0, 0xA1, 0xA2, 0xB0..0xB6.
  - Count must stay 3 throughout.
- Push into empty: a single push of 0x5A gives `output_valid`=1 with 0x5A on the next cycle. Popping it returns `output_valid`=0 on the cycle after that.
- Full with pop: at count=32 (DEPTH=32), assert `input_valid` and `output_ready` together.
  - Only the pop occurs; count becomes 31.
  - `input_ready` rises on the next cycle.
- Mid-operation clear: at count=7, assert `clear` together with a push and a pop. Next cycle count is 0 and `output_valid`=0. A subsequent push of 0x33 is output as 0x33, with no stale data visible.
